// File: rtl/cbs_credit_shaper_if.sv
// Egress-queue AXIS handshake seen by the credit-based shaper.
// The shaper only observes the handshake, so it connects through the monitor view.
interface cbs_credit_shaper_if;
    logic tvalid;
    logic tready;
    logic tlast;

    // Valid/ready: a beat transfers on every axis_aclk edge where tvalid and tready are both high;
    // tlast qualifies the transferring beat as the end of a frame.
    modport master  (output tvalid, output tlast, input  tready);
    modport slave   (input  tvalid, input  tlast, output tready);
    modport monitor (input  tvalid, input  tlast, input  tready);
endinterface

// File: rtl/cbs_credit_shaper.sv
// Per-queue credit-based shaper: tracks signed credit beat by beat and
// produces the queue eligibility handed to the strict-priority selector.
module cbs_credit_shaper #(
    parameter int CREDIT_WIDTH = 32,
    parameter int SLOPE_WIDTH  = 16,
    parameter int STAT_WIDTH   = 32
) (
    input  logic                           axis_aclk,
    input  logic                           axis_reset,
    cbs_credit_shaper_if.monitor           axis,
    input  logic                           gate_open,
    input  logic                           cbs_enable,
    input  logic        [SLOPE_WIDTH-1:0]  idle_slope,
    input  logic        [SLOPE_WIDTH-1:0]  send_slope,
    input  logic signed [CREDIT_WIDTH-1:0] hi_credit,
    input  logic signed [CREDIT_WIDTH-1:0] lo_credit,
    input  logic                           stat_clear,
    output logic                           queue_valid,
    output logic signed [CREDIT_WIDTH-1:0] credit,
    output logic                           in_frame,
    output logic        [STAT_WIDTH-1:0]   blocked_cycles
);

    localparam int EW = CREDIT_WIDTH + 1;

    typedef enum logic {IDLE = 1'b0, XMIT = 1'b1} state_t;

    state_t state, state_next;
    logic   beat;
    logic   xmit;
    logic   credit_neg;

    logic signed [EW-1:0]           cur_ext, idle_ext, send_ext, hi_ext, lo_ext, raw;
    logic                           do_clamp;
    logic signed [CREDIT_WIDTH-1:0] credit_next;

    assign beat       = axis.tvalid & axis.tready;
    assign xmit       = (state == XMIT) | beat;
    assign credit_neg = credit[CREDIT_WIDTH-1];
    assign in_frame   = (state == XMIT);

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) state <= IDLE;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (beat && !axis.tlast) state_next = XMIT;
            XMIT:    if (beat &&  axis.tlast) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // One bit of headroom so slope add/subtract cannot wrap before clamping.
    always_comb begin
        cur_ext  = EW'(credit);
        idle_ext = {{(EW-SLOPE_WIDTH){1'b0}}, idle_slope};
        send_ext = {{(EW-SLOPE_WIDTH){1'b0}}, send_slope};
        hi_ext   = EW'(hi_credit);
        lo_ext   = EW'(lo_credit);
        raw      = cur_ext;
        do_clamp = 1'b0;
        if (xmit) begin
            raw      = cur_ext - send_ext;
            do_clamp = 1'b1;
        end else if (!gate_open) begin
            raw = cur_ext;
        end else if (axis.tvalid) begin
            raw      = cur_ext + idle_ext;
            do_clamp = 1'b1;
        end else if (credit_neg) begin
            raw      = cur_ext + idle_ext;
            if (raw > 0) raw = '0;
            do_clamp = 1'b1;
        end else begin
            raw = '0;
        end
        // Low limit applied last so it wins when the limits cross.
        if (do_clamp) begin
            if (raw > hi_ext) raw = hi_ext;
            if (raw < lo_ext) raw = lo_ext;
        end
        credit_next = raw[CREDIT_WIDTH-1:0];
        if (!cbs_enable) credit_next = '0;
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) credit <= '0;
        else            credit <= credit_next;
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            blocked_cycles <= '0;
        end else if (stat_clear) begin
            blocked_cycles <= '0;
        end else if (cbs_enable && axis.tvalid && !in_frame && credit_neg
                     && (blocked_cycles != {STAT_WIDTH{1'b1}})) begin
            blocked_cycles <= blocked_cycles + 1'b1;
        end
    end

    // A started frame stays eligible even once its credit has gone negative.
    assign queue_valid = !axis_reset &&
                         (cbs_enable ? (axis.tvalid && (!credit_neg || in_frame))
                                     : axis.tvalid);

endmodule

// File: tb/tb_cbs_credit_shaper.sv
// Directed bench for cbs_credit_shaper with hand-computed credit trajectories.
module tb_cbs_credit_shaper;

    logic               axis_aclk;
    logic               axis_reset;
    logic               gate_open;
    logic               cbs_enable;
    logic        [15:0] idle_slope;
    logic        [15:0] send_slope;
    logic signed [31:0] hi_credit;
    logic signed [31:0] lo_credit;
    logic               stat_clear;
    logic               queue_valid;
    logic signed [31:0] credit;
    logic               in_frame;
    logic        [31:0] blocked_cycles;

    int n_compared   = 0;
    int n_mismatched = 0;

    cbs_credit_shaper_if axis ();

    cbs_credit_shaper dut (
        .axis_aclk      (axis_aclk),
        .axis_reset     (axis_reset),
        .axis           (axis.monitor),
        .gate_open      (gate_open),
        .cbs_enable     (cbs_enable),
        .idle_slope     (idle_slope),
        .send_slope     (send_slope),
        .hi_credit      (hi_credit),
        .lo_credit      (lo_credit),
        .stat_clear     (stat_clear),
        .queue_valid    (queue_valid),
        .credit         (credit),
        .in_frame       (in_frame),
        .blocked_cycles (blocked_cycles)
    );

    // clock / reset
    initial axis_aclk = 1'b0;
    always #5 axis_aclk = ~axis_aclk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic r, input logic l);
        axis.tvalid = v;
        axis.tready = r;
        axis.tlast  = l;
    endtask

    initial begin
        axis_reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        gate_open  = 1'b1;
        cbs_enable = 1'b1;
        idle_slope = 16'd4;
        send_slope = 16'd12;
        hi_credit  = 32'sd1000;
        lo_credit  = -32'sd1000;
        stat_clear = 1'b0;
        repeat (3) tick();
        check("rst_credit", credit, 0);
        check("rst_in_frame", in_frame, 0);
        check("rst_blocked", blocked_cycles, 0);
        check("rst_queue_valid", queue_valid, 0);
        axis_reset = 1'b0;
        tick();
        check("idle_credit", credit, 0);

        // three-beat frame: 0 -> -12 -> -24 -> -36
        drive(1'b1, 1'b1, 1'b0);
        tick();
        check("f1_credit", credit, -12);
        check("f1_in_frame", in_frame, 1);
        tick();
        check("f2_credit", credit, -24);
        check("f2_in_frame", in_frame, 1);
        drive(1'b1, 1'b1, 1'b1);
        tick();
        check("f3_credit", credit, -36);
        check("f3_in_frame", in_frame, 0);

        // recovery while next frame waits: low for 9 cycles (-36 .. -4)
        drive(1'b1, 1'b0, 1'b0);
        #1;
        check("rec_qv_0", queue_valid, 0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("rec_qv", queue_valid, (k == 9) ? 1 : 0);
        end
        check("rec_credit", credit, 0);
        check("rec_blocked", blocked_cycles, 9);
        stat_clear = 1'b1;
        tick();
        stat_clear = 1'b0;
        check("stat_clear", blocked_cycles, 0);
        check("rec_credit_up", credit, 4);

        // empty queue drops positive credit to zero
        drive(1'b0, 1'b0, 1'b0);
        tick();
        check("empty_pos_a", credit, 0);
        idle_slope = 16'd20;
        drive(1'b1, 1'b0, 1'b0);
        tick();
        check("empty_pos_20", credit, 20);
        drive(1'b0, 1'b0, 1'b0);
        tick();
        check("empty_pos_0", credit, 0);

        // empty queue recovers negative credit up to zero
        send_slope = 16'd10;
        drive(1'b1, 1'b1, 1'b1);
        tick();
        check("single_beat", credit, -10);
        check("single_in_frame", in_frame, 0);
        idle_slope = 16'd4;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        check("neg_rec_a", credit, -6);
        tick();
        check("neg_rec_b", credit, -2);
        tick();
        check("neg_rec_c", credit, 0);
        tick();
        check("neg_rec_hold", credit, 0);

        // gate closed freezes credit
        send_slope = 16'd40;
        drive(1'b1, 1'b1, 1'b1);
        tick();
        check("gate_pre", credit, -40);
        drive(1'b1, 1'b0, 1'b0);
        gate_open = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("gate_hold", credit, -40);
        end

        // gate closing mid-frame does not stop the send-slope drain
        gate_open  = 1'b1;
        send_slope = 16'd12;
        drive(1'b1, 1'b1, 1'b0);
        tick();
        check("gx_start", credit, -52);
        gate_open = 1'b0;
        drive(1'b1, 1'b0, 1'b0);
        tick();
        check("gx_stall_a", credit, -64);
        tick();
        check("gx_stall_b", credit, -76);
        check("gx_in_frame", in_frame, 1);
        check("gx_qv_in_frame", queue_valid, 1);
        drive(1'b1, 1'b1, 1'b1);
        tick();
        check("gx_end", credit, -88);
        check("gx_end_in_frame", in_frame, 0);
        gate_open = 1'b1;
        drive(1'b0, 1'b0, 1'b0);

        // clamps
        cbs_enable = 1'b0;
        tick();
        check("dis_zero", credit, 0);
        cbs_enable = 1'b1;
        hi_credit  = 32'sd50;
        idle_slope = 16'd30;
        drive(1'b1, 1'b0, 1'b0);
        tick();
        check("hi_a", credit, 30);
        tick();
        check("hi_b", credit, 50);
        tick();
        check("hi_c", credit, 50);
        send_slope = 16'd600;
        lo_credit  = -32'sd500;
        drive(1'b1, 1'b1, 1'b1);
        tick();
        check("lo_a", credit, -500);
        tick();
        check("lo_b", credit, -500);
        drive(1'b1, 1'b0, 1'b0);
        #1;
        check("lo_qv", queue_valid, 0);

        // asynchronous reset mid-frame
        drive(1'b0, 1'b0, 1'b0);
        hi_credit  = 32'sd1000;
        lo_credit  = -32'sd1000;
        send_slope = 16'd12;
        idle_slope = 16'd4;
        cbs_enable = 1'b0;
        tick();
        cbs_enable = 1'b1;
        drive(1'b1, 1'b1, 1'b0);
        tick();
        tick();
        check("mid_credit", credit, -24);
        check("mid_in_frame", in_frame, 1);
        #2;
        axis_reset = 1'b1;
        #1;
        check("arst_credit", credit, 0);
        check("arst_in_frame", in_frame, 0);
        check("arst_qv", queue_valid, 0);
        #1;
        axis_reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0);
        tick();
        check("post_rst", credit, 0);

        // disabling shaping turns the queue into pass-through
        drive(1'b1, 1'b1, 1'b1);
        tick();
        check("dis_pre", credit, -12);
        drive(1'b1, 1'b0, 1'b0);
        #1;
        check("dis_qv_en", queue_valid, 0);
        cbs_enable = 1'b0;
        #1;
        check("dis_qv", queue_valid, 1);
        tick();
        check("dis_credit", credit, 0);
        check("dis_qv_after", queue_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
